// File: rtl/rvfi_step_sched_pkg.sv
// Shared types and constants for the RVFI step scheduler and its retirement queue.
package rvfi_step_sched_pkg;

    parameter int RVFI_XLEN = 64;
    parameter int RVFI_ILEN = 32;
    parameter int MAX_NRET  = 4;
    localparam int MISMATCH_CNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_CHECK,
        ST_HALT
    } sched_state_e;

    typedef struct packed {
        logic [RVFI_XLEN-1:0] pc;
        logic [RVFI_ILEN-1:0] insn;
    } rvfi_entry_t;

    function automatic logic [2:0] popcount(input logic [MAX_NRET-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < MAX_NRET; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/rvfi_step_fifo.sv
// Multi-push / single-pop circular buffer: a retirement beat is taken whole or dropped whole.
module rvfi_step_fifo
    import rvfi_step_sched_pkg::*;
#(
    parameter int NRET  = 2,
    parameter int DEPTH = 8,
    parameter int W     = 96,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NRET-1:0]        push_valid_i,
    input  logic [NRET-1:0][W-1:0] push_data_i,
    input  logic                   pop_i,
    output logic [W-1:0]           head_o,
    output logic [CW-1:0]          count_o,
    output logic [CW-1:0]          count_next_o,
    output logic                   overflow_o
);

    logic [W-1:0]            mem [DEPTH];
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]           count_q, push_cnt;
    logic                    accept;
    logic                    overflow_q;
    logic [NRET-1:0][PW-1:0] lane_off;

    // Each valid lane lands at the tail plus the number of valid lanes below it.
    always_comb begin
        push_cnt = CW'(popcount(MAX_NRET'(push_valid_i)));
        for (int i = 0; i < NRET; i++) begin
            lane_off[i] = PW'(popcount(MAX_NRET'(push_valid_i) & MAX_NRET'((1 << i) - 1)));
        end
    end

    // Full check uses pre-pop occupancy, so a pop in the same cycle never frees room.
    assign accept       = push_cnt <= (CW'(DEPTH) - count_q);
    assign count_next_o = count_q + (accept ? push_cnt : '0) - CW'(pop_i);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) wr_ptr_q <= wr_ptr_q + PW'(push_cnt);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_next_o;
            if (!accept) overflow_q <= 1'b1;
        end
    end

    // NOTE: storage is left unreset; count_q alone decides which slots hold live data.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            for (int i = 0; i < NRET; i++) begin
                if (push_valid_i[i]) mem[wr_ptr_q + lane_off[i]] <= push_data_i[i];
            end
        end
    end

    assign head_o     = mem[rd_ptr_q];
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/rvfi_step_scheduler.sv
// Queues RVFI retirements, steps the ISS one instruction at a time and compares PC/insn.
// Optional: REFMODEL_MISMATCH_HALT_EN parks the scheduler in HALT on the first mismatch.
module rvfi_step_scheduler
    import rvfi_step_sched_pkg::*;
#(
    parameter int NRET  = 2,
    parameter int XLEN  = RVFI_XLEN,
    parameter int ILEN  = RVFI_ILEN,
    parameter int DEPTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NRET-1:0]              rvfi_valid_i,
    input  logic [NRET-1:0][XLEN-1:0]    rvfi_pc_i,
    input  logic [NRET-1:0][ILEN-1:0]    rvfi_insn_i,
    output logic                         step_req_o,
    input  logic                         step_ack_i,
    input  logic [XLEN-1:0]              iss_pc_i,
    input  logic [ILEN-1:0]              iss_insn_i,
    output logic                         busy_o,
    output logic [$clog2(DEPTH):0]       fifo_count_o,
    output logic                         overflow_o,
    output logic                         mismatch_o,
    output logic [MISMATCH_CNT_W-1:0]    mismatch_cnt_o,
    output logic                         halted_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    sched_state_e              state_q, state_d;
    rvfi_entry_t [NRET-1:0]    push_data;
    rvfi_entry_t               head, iss_q;
    logic [CW-1:0]             count, count_next;
    logic                      pop, mismatch_d, mismatch_q;
    logic [MISMATCH_CNT_W-1:0] mismatch_cnt_q;

    always_comb begin
        for (int i = 0; i < NRET; i++) begin
            push_data[i] = '{pc: rvfi_pc_i[i], insn: rvfi_insn_i[i]};
        end
    end

    rvfi_step_fifo #(
        .NRET  (NRET),
        .DEPTH (DEPTH),
        .W     ($bits(rvfi_entry_t))
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_valid_i (rvfi_valid_i),
        .push_data_i  (push_data),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (count),
        .count_next_o (count_next),
        .overflow_o   (overflow_o)
    );

    // NOTE: every variable driven here gets a default first so no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        mismatch_d = 1'b0;
        unique case (state_q)
            ST_IDLE:  if (count != '0) state_d = ST_REQ;
            ST_REQ:   if (step_ack_i) state_d = ST_CHECK;
            ST_CHECK: begin
                pop        = 1'b1;
                mismatch_d = (iss_q != head);
`ifdef REFMODEL_MISMATCH_HALT_EN
                if (mismatch_d)                state_d = ST_HALT;
                else if (count_next != '0)     state_d = ST_REQ;
                else                           state_d = ST_IDLE;
`else
                state_d = (count_next != '0) ? ST_REQ : ST_IDLE;
`endif
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            iss_q          <= '0;
            mismatch_q     <= 1'b0;
            mismatch_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mismatch_q <= mismatch_d;
            if (state_q == ST_REQ && step_ack_i) iss_q <= '{pc: iss_pc_i, insn: iss_insn_i};
            if (mismatch_d && mismatch_cnt_q != '1) mismatch_cnt_q <= mismatch_cnt_q + 1'b1;
        end
    end

    assign step_req_o     = (state_q == ST_REQ);
    assign busy_o         = (count != '0) || (state_q != ST_IDLE);
    assign fifo_count_o   = count;
    assign mismatch_o     = mismatch_q;
    assign mismatch_cnt_o = mismatch_cnt_q;
`ifdef REFMODEL_MISMATCH_HALT_EN
    assign halted_o = (state_q == ST_HALT);
`else
    assign halted_o = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_step_scheduler.sv
// Self-checking bench: directed scenarios plus a randomized run against a queue-level model.
module tb_rvfi_step_scheduler;

    localparam int NRET  = 2;
    localparam int XLEN  = 64;
    localparam int ILEN  = 32;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] insn;
    } ent_t;

    logic                      clk_i = 1'b0;
    logic                      rst_ni;
    logic [NRET-1:0]           rvfi_valid;
    logic [NRET-1:0][XLEN-1:0] rvfi_pc;
    logic [NRET-1:0][ILEN-1:0] rvfi_insn;
    logic                      step_req_o;
    logic                      step_ack;
    logic [XLEN-1:0]           iss_pc;
    logic [ILEN-1:0]           iss_insn;
    logic                      busy_o;
    logic [$clog2(DEPTH):0]    fifo_count_o;
    logic                      overflow_o;
    logic                      mismatch_o;
    logic [31:0]               mismatch_cnt_o;
    logic                      halted_o;

    int errors = 0;
    int checks = 0;

    rvfi_step_scheduler #(.NRET(NRET), .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .rvfi_valid_i   (rvfi_valid),
        .rvfi_pc_i      (rvfi_pc),
        .rvfi_insn_i    (rvfi_insn),
        .step_req_o     (step_req_o),
        .step_ack_i     (step_ack),
        .iss_pc_i       (iss_pc),
        .iss_insn_i     (iss_insn),
        .busy_o         (busy_o),
        .fifo_count_o   (fifo_count_o),
        .overflow_o     (overflow_o),
        .mismatch_o     (mismatch_o),
        .mismatch_cnt_o (mismatch_cnt_o),
        .halted_o       (halted_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        rvfi_valid = '0;
        rvfi_pc    = '0;
        rvfi_insn  = '0;
        step_ack   = 1'b0;
        iss_pc     = '0;
        iss_insn   = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_ni = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
    endtask

    task automatic drive_push(input logic [1:0] v, input logic [63:0] pc0, input logic [31:0] i0,
                              input logic [63:0] pc1, input logic [31:0] i1);
        rvfi_valid   = v;
        rvfi_pc[0]   = pc0;
        rvfi_insn[0] = i0;
        rvfi_pc[1]   = pc1;
        rvfi_insn[1] = i1;
    endtask

    task automatic drive_ack(input logic [63:0] pc, input logic [31:0] insn);
        step_ack = 1'b1;
        iss_pc   = pc;
        iss_insn = insn;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!step_req_o && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (!step_req_o) begin
            errors++;
            $display("FAIL %s wait_req: step_req_o stayed 0 for 20 cycles", tag);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 7;
        if (step_req_o !== 1'b0)      begin errors++; $display("FAIL reset step_req: got %b want 0", step_req_o); end
        if (busy_o !== 1'b0)          begin errors++; $display("FAIL reset busy: got %b want 0", busy_o); end
        if (fifo_count_o !== 4'd0)    begin errors++; $display("FAIL reset count: got %0d want 0", fifo_count_o); end
        if (overflow_o !== 1'b0)      begin errors++; $display("FAIL reset overflow: got %b want 0", overflow_o); end
        if (mismatch_o !== 1'b0)      begin errors++; $display("FAIL reset mismatch: got %b want 0", mismatch_o); end
        if (mismatch_cnt_o !== 32'd0) begin errors++; $display("FAIL reset mismatch_cnt: got %0d want 0", mismatch_cnt_o); end
        if (halted_o !== 1'b0)        begin errors++; $display("FAIL reset halted: got %b want 0", halted_o); end
    endtask

    task automatic test_single();
        drive_push(2'b01, 64'h8000_0000, 32'h0000_0013, 64'h0, 32'h0);
        step();                                   // t+1
        clear_inputs();
        checks += 2;
        if (fifo_count_o !== 4'd1) begin errors++; $display("FAIL single count_t1: got %0d want 1", fifo_count_o); end
        if (step_req_o !== 1'b0)   begin errors++; $display("FAIL single req_t1: got %b want 0", step_req_o); end
        step();                                   // t+2
        checks++;
        if (step_req_o !== 1'b1)   begin errors++; $display("FAIL single req_t2: got %b want 1", step_req_o); end
        drive_ack(64'h8000_0000, 32'h0000_0013);
        step();                                   // a+1
        clear_inputs();
        checks += 2;
        if (step_req_o !== 1'b0)   begin errors++; $display("FAIL single req_check: got %b want 0", step_req_o); end
        if (busy_o !== 1'b1)       begin errors++; $display("FAIL single busy_a1: got %b want 1", busy_o); end
        step();                                   // a+2
        checks += 4;
        if (busy_o !== 1'b0)          begin errors++; $display("FAIL single busy_a2: got %b want 0", busy_o); end
        if (fifo_count_o !== 4'd0)    begin errors++; $display("FAIL single count_a2: got %0d want 0", fifo_count_o); end
        if (mismatch_o !== 1'b0)      begin errors++; $display("FAIL single mismatch: got %b want 0", mismatch_o); end
        if (mismatch_cnt_o !== 32'd0) begin errors++; $display("FAIL single mismatch_cnt: got %0d want 0", mismatch_cnt_o); end
    endtask

    task automatic test_dual();
        drive_push(2'b11, 64'h100, 32'h0000_0013, 64'h104, 32'h0010_0093);
        step();
        clear_inputs();
        checks++;
        if (fifo_count_o !== 4'd2) begin errors++; $display("FAIL dual count_2: got %0d want 2", fifo_count_o); end
        wait_req("dual0");
        drive_ack(64'h100, 32'h0000_0013);
        step();
        clear_inputs();
        step();
        checks += 3;
        if (fifo_count_o !== 4'd1) begin errors++; $display("FAIL dual count_1: got %0d want 1", fifo_count_o); end
        if (mismatch_o !== 1'b0)   begin errors++; $display("FAIL dual mismatch0: got %b want 0", mismatch_o); end
        if (step_req_o !== 1'b1)   begin errors++; $display("FAIL dual req1: got %b want 1", step_req_o); end
        drive_ack(64'h104, 32'h0010_0093);
        step();
        clear_inputs();
        step();
        checks += 3;
        if (fifo_count_o !== 4'd0)    begin errors++; $display("FAIL dual count_0: got %0d want 0", fifo_count_o); end
        if (mismatch_o !== 1'b0)      begin errors++; $display("FAIL dual mismatch1: got %b want 0", mismatch_o); end
        if (mismatch_cnt_o !== 32'd0) begin errors++; $display("FAIL dual mismatch_cnt: got %0d want 0", mismatch_cnt_o); end
    endtask

    task automatic test_overflow();
        int exp_cnt;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            drive_push(2'b11, {$urandom, $urandom}, $urandom, {$urandom, $urandom}, $urandom);
            step();
            exp_cnt = (2 * i > DEPTH) ? DEPTH : 2 * i;
            checks += 2;
            if (fifo_count_o !== 4'(exp_cnt)) begin errors++; $display("FAIL overflow count_beat%0d: got %0d want %0d", i, fifo_count_o, exp_cnt); end
            if (overflow_o !== (i == 5))      begin errors++; $display("FAIL overflow flag_beat%0d: got %b want %b", i, overflow_o, i == 5); end
        end
        drive_push(2'b01, 64'h0, 32'h0, 64'h0, 32'h0);
        step();
        clear_inputs();
        step();
        checks += 2;
        if (fifo_count_o !== 4'd8) begin errors++; $display("FAIL overflow count_hold: got %0d want 8", fifo_count_o); end
        if (overflow_o !== 1'b1)   begin errors++; $display("FAIL overflow sticky: got %b want 1", overflow_o); end
    endtask

    task automatic test_mismatch();
        do_reset();
        drive_push(2'b11, 64'h100, 32'h0000_0013, 64'h104, 32'h0000_0093);
        step();
        clear_inputs();
        wait_req("mismatch");
        drive_ack(64'h104, 32'h0000_0013);
        step();                                   // a+1
        clear_inputs();
        checks++;
        if (mismatch_o !== 1'b0) begin errors++; $display("FAIL mismatch early: got %b want 0", mismatch_o); end
        step();                                   // a+2
        checks += 2;
        if (mismatch_o !== 1'b1)      begin errors++; $display("FAIL mismatch pulse: got %b want 1", mismatch_o); end
        if (mismatch_cnt_o !== 32'd1) begin errors++; $display("FAIL mismatch cnt: got %0d want 1", mismatch_cnt_o); end
`ifdef REFMODEL_MISMATCH_HALT_EN
        checks += 2;
        if (halted_o !== 1'b1)   begin errors++; $display("FAIL mismatch halted: got %b want 1", halted_o); end
        if (step_req_o !== 1'b0) begin errors++; $display("FAIL mismatch halt_req: got %b want 0", step_req_o); end
        drive_push(2'b01, 64'h108, 32'h13, 64'h0, 32'h0);
        step();
        clear_inputs();
        checks += 3;
        if (mismatch_o !== 1'b0)   begin errors++; $display("FAIL mismatch pulse_end: got %b want 0", mismatch_o); end
        if (fifo_count_o !== 4'd2) begin errors++; $display("FAIL mismatch halt_push: got %0d want 2", fifo_count_o); end
        if (busy_o !== 1'b1)       begin errors++; $display("FAIL mismatch halt_busy: got %b want 1", busy_o); end
        for (int i = 0; i < 4; i++) begin
            step_ack = 1'b1;
            step();
            checks++;
            if (step_req_o !== 1'b0 || halted_o !== 1'b1) begin
                errors++; $display("FAIL mismatch halt_hold%0d: req=%b halted=%b want req=0 halted=1", i, step_req_o, halted_o);
            end
        end
        clear_inputs();
`else
        checks += 2;
        if (halted_o !== 1'b0)   begin errors++; $display("FAIL mismatch halted: got %b want 0", halted_o); end
        if (step_req_o !== 1'b1) begin errors++; $display("FAIL mismatch next_req: got %b want 1", step_req_o); end
        drive_ack(64'h104, 32'h0000_0093);
        step();
        clear_inputs();
        checks++;
        if (mismatch_o !== 1'b0) begin errors++; $display("FAIL mismatch pulse_end: got %b want 0", mismatch_o); end
        step();
        checks += 3;
        if (mismatch_o !== 1'b0)      begin errors++; $display("FAIL mismatch second: got %b want 0", mismatch_o); end
        if (mismatch_cnt_o !== 32'd1) begin errors++; $display("FAIL mismatch cnt_hold: got %0d want 1", mismatch_cnt_o); end
        if (fifo_count_o !== 4'd0)    begin errors++; $display("FAIL mismatch drained: got %0d want 0", fifo_count_o); end
`endif
    endtask

    task automatic test_push_during_check();
        do_reset();
        drive_push(2'b01, 64'h200, 32'h13, 64'h0, 32'h0);
        step();
        clear_inputs();
        wait_req("pdc");
        drive_ack(64'h200, 32'h13);
        step();                                   // CHECK, count 1
        clear_inputs();
        checks++;
        if (fifo_count_o !== 4'd1) begin errors++; $display("FAIL pdc count_check: got %0d want 1", fifo_count_o); end
        drive_push(2'b11, 64'h204, 32'h93, 64'h208, 32'h113);
        step();
        clear_inputs();
        checks += 3;
        if (fifo_count_o !== 4'd2) begin errors++; $display("FAIL pdc count_after: got %0d want 2", fifo_count_o); end
        if (step_req_o !== 1'b1)   begin errors++; $display("FAIL pdc req: got %b want 1", step_req_o); end
        if (mismatch_o !== 1'b0)   begin errors++; $display("FAIL pdc mismatch: got %b want 0", mismatch_o); end
        drive_ack(64'h204, 32'h93);
        step();
        clear_inputs();
        step();
        checks += 2;
        if (mismatch_o !== 1'b0)   begin errors++; $display("FAIL pdc order: got %b want 0", mismatch_o); end
        if (fifo_count_o !== 4'd1) begin errors++; $display("FAIL pdc count_end: got %0d want 1", fifo_count_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive_push(2'b11, 64'h300, 32'h1, 64'h304, 32'h2);
        step();
        drive_push(2'b01, 64'h308, 32'h3, 64'h0, 32'h0);
        step();
        clear_inputs();
        checks += 2;
        if (fifo_count_o !== 4'd3) begin errors++; $display("FAIL rstmid pre_count: got %0d want 3", fifo_count_o); end
        if (step_req_o !== 1'b1)   begin errors++; $display("FAIL rstmid pre_req: got %b want 1", step_req_o); end
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        checks += 4;
        if (fifo_count_o !== 4'd0) begin errors++; $display("FAIL rstmid count: got %0d want 0", fifo_count_o); end
        if (step_req_o !== 1'b0)   begin errors++; $display("FAIL rstmid req: got %b want 0", step_req_o); end
        if (busy_o !== 1'b0)       begin errors++; $display("FAIL rstmid busy: got %b want 0", busy_o); end
        if (overflow_o !== 1'b0 || mismatch_o !== 1'b0 || halted_o !== 1'b0 || mismatch_cnt_o !== 32'd0) begin
            errors++; $display("FAIL rstmid flags: ovf=%b mm=%b halt=%b cnt=%0d want all 0", overflow_o, mismatch_o, halted_o, mismatch_cnt_o);
        end
        step();
        checks++;
        if (step_req_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL rstmid after: req=%b busy=%b want 0/0", step_req_o, busy_o);
        end
    endtask

    task automatic test_random();
        ent_t        mq[$];
        ent_t        e;
        logic [95:0] flip;
        logic [1:0]  v;
        bit          chk_now = 0, chk_mm = 0, m_mm = 0, m_ovf = 0, corrupt, acc;
        int          m_cnt = 0, run = 0, n;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            checks += 5;
            if (fifo_count_o !== 4'(mq.size())) begin errors++; $display("FAIL rand count@%0d: got %0d want %0d", cyc, fifo_count_o, mq.size()); end
            if (overflow_o !== m_ovf)           begin errors++; $display("FAIL rand overflow@%0d: got %b want %b", cyc, overflow_o, m_ovf); end
            if (mismatch_o !== m_mm)            begin errors++; $display("FAIL rand mismatch@%0d: got %b want %b", cyc, mismatch_o, m_mm); end
            if (mismatch_cnt_o !== 32'(m_cnt))  begin errors++; $display("FAIL rand mm_cnt@%0d: got %0d want %0d", cyc, mismatch_cnt_o, m_cnt); end
            if (step_req_o && (mq.size() == 0 || chk_now)) begin
                errors++; $display("FAIL rand req_illegal@%0d: got req=1 with size=%0d check=%b", cyc, mq.size(), chk_now);
            end
            run = (mq.size() > 0 && !step_req_o && !chk_now) ? run + 1 : 0;
            checks++;
            if (run > 1) begin errors++; $display("FAIL rand req_late@%0d: idle run %0d want <=1", cyc, run); end

            clear_inputs();
            v = (cyc >= 2000) ? 2'($urandom_range(0, 3)) : (($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
            drive_push(v, {$urandom, $urandom}, $urandom, {$urandom, $urandom}, $urandom);
            corrupt = 1'b0;
            if (step_req_o && mq.size() > 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    e = mq[0];
`ifndef REFMODEL_MISMATCH_HALT_EN
                    corrupt = ($urandom_range(0, 3) == 0);
`endif
                    if (corrupt) begin
                        flip = 96'd1 << $urandom_range(0, 95);
                        e = e ^ flip;
                    end
                    drive_ack(e.pc, e.insn);
                end
            end else if ($urandom_range(0, 3) == 0) begin
                drive_ack({$urandom, $urandom}, $urandom);
            end

            n   = int'(v[0]) + int'(v[1]);
            acc = (DEPTH - mq.size()) >= n;
            if (!acc) m_ovf = 1'b1;
            m_mm = chk_now && chk_mm;
            if (m_mm) m_cnt++;
            if (chk_now && mq.size() > 0) void'(mq.pop_front());
            if (acc) begin
                for (int l = 0; l < NRET; l++) begin
                    if (v[l]) mq.push_back('{pc: rvfi_pc[l], insn: rvfi_insn[l]});
                end
            end
            chk_now = step_req_o && step_ack;
            chk_mm  = corrupt;
            step();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_ni = 1'b0;
        test_reset();
        test_single();
        test_dual();
        test_overflow();
        test_mismatch();
        test_push_during_check();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rvfi_step_scheduler.md
# rvfi_step_scheduler

Sequences the instruction-set simulator against the DUT's RVFI retirement stream. Each cycle, up to NRET retirements are queued in program order. The scheduler then issues one step request at a time to the reference-model stepping interface. It compares the returned PC/instruction with the queued DUT entry and reports mismatches. It sits between the RVFI instruction interface and the ISS step wrapper inside the reference-model shell.

## Interface
- NRET, 2: retirement lanes per cycle (1..4)
- XLEN, 64: PC width
- ILEN, 32: instruction width
- DEPTH, 8: queue entries (power of two, ≥ 2·NRET)
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- rvfi_valid_i  in  NRET  per-lane retirement valid; lane 0 is oldest
- rvfi_pc_i  in  NRET×XLEN  per-lane retired PC
- rvfi_insn_i  in  NRET×ILEN  per-lane retired instruction
- step_req_o  out  1  request one ISS step
- step_ack_i  in  1  ISS step done, result valid this cycle
- iss_pc_i  in  XLEN  ISS PC, sampled on ack
- iss_insn_i  in  ILEN  ISS instruction, sampled on ack
- busy_o  out  1  queue non-empty or FSM not IDLE
- fifo_count_o  out  $clog2(DEPTH)+1  occupancy
- overflow_o  out  1  sticky: a retirement beat was dropped
- mismatch_o  out  1  one-cycle pulse on compare failure
- mismatch_cnt_o  out  32  saturating mismatch count
- halted_o  out  1  scheduler in HALT

## Operation
- Push: valid lanes compacted in lane order, appended at the tail in one cycle.
- The whole beat is accepted only if the free slots are ≥ popcount(rvfi_valid_i). Otherwise the whole beat is dropped and overflow_o is set. It is cleared only by reset.
- FSM states: IDLE, REQ, CHECK, HALT.
- IDLE → REQ when count > 0.
- REQ: step_req_o = 1. Holds until step_ack_i. On ack, latch iss_pc_i/iss_insn_i and go to CHECK. step_ack_i outside REQ is ignored.
- CHECK: compare the latched result with the queue head (PC and instruction), then pop the head.
  - On mismatch: mismatch_o pulses and mismatch_cnt_o increments, saturating at 2^32−1.
  - Next state: REQ if the post-pop count > 0, else IDLE. This is subject to the Configuration section.
- HALT: absorbing until reset. Pushes continue to be accepted or dropped normally.
- Simultaneous push and pop in CHECK: count_next = count + pushes − 1. The full check uses pre-pop occupancy.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. The count is tracked separately.

## Timing
- Reset values:
  - state IDLE
  - step_req_o 0, busy_o 0, fifo_count_o 0
  - overflow_o 0, mismatch_o 0, mismatch_cnt_o 0, halted_o 0
  - pointers 0
- A retirement pushed at cycle t is counted at t+1. IDLE→REQ happens at t+1, so step_req_o is high from t+2.
- Ack at cycle a puts the FSM in CHECK at a+1. mismatch_o is registered and is visible at a+2. Pop takes effect at a+2.
- Steady-state throughput is one step per 2 cycles with single-cycle ack.
- Reset mid-operation discards the queue and any outstanding request. The ISS wrapper must tolerate an abandoned request.

## Configuration
- REFMODEL_MISMATCH_HALT_EN defined: a mismatch in CHECK transitions to HALT. halted_o = 1 and step_req_o stays 0.
- Not defined: mismatches are counted and sequencing continues. HALT is unreachable and halted_o is tied 0.

## Structure
- Package rvfi_step_sched_pkg:
  - sched_state_e enum
  - rvfi_entry_t struct (pc, insn), parameterised by XLEN/ILEN via package parameters
  - MISMATCH_CNT_W = 32
- One sub-module, rvfi_step_fifo: multi-push (NRET), single-pop circular buffer with count, full-beat check and overflow flag.
- The top level holds the FSM, result latch, comparator and counters.

## Test plan
- Single retirement: lane0 pc 0x8000_0000 / insn 0x0000_0013, ISS acks the same values at the first REQ → one step, no mismatch, busy_o drops 2 cycles after the ack.
- Dual retirement: lanes 0/1 at pc 0x100/0x104 in one cycle → two REQs in order 0x100 then 0x104, fifo_count_o goes 2→1→0.
- Overflow: DEPTH=8, ISS never acks, push 2/cycle for 5 cycles → count 8, overflow_o = 1 from the 5th beat, count stays 8.
- Mismatch: ISS returns pc 0x104 against queued 0x100 → mismatch_o pulse, mismatch_cnt_o = 1. With the macro, halted_o = 1 and no further step_req_o; without it, the next entry is requested.
- Push during CHECK at count 1 with 2 new lanes → count becomes 2 the next cycle, FSM goes to REQ.
- Reset asserted while in REQ with count 3 → next cycle all outputs are at reset values and the queue is empty.
